// File: rtl/vdp_slot_io_bridge_if.sv
// Request channel between the slot I/O bridge and the VDP core.
// The bridge is the master: it issues valid/ready requests and receives read data
// on a one-cycle bus_rdata_en strobe.
interface vdp_slot_io_bridge_if;
  logic       bus_valid;
  logic       bus_ready;
  logic       bus_write;
  logic [1:0] bus_address;
  logic [7:0] bus_wdata;
  logic [7:0] bus_rdata;
  logic       bus_rdata_en;

  modport master (
    output bus_valid,
    output bus_write,
    output bus_address,
    output bus_wdata,
    input  bus_ready,
    input  bus_rdata,
    input  bus_rdata_en
  );

  modport slave (
    input  bus_valid,
    input  bus_write,
    input  bus_address,
    input  bus_wdata,
    output bus_ready,
    output bus_rdata,
    output bus_rdata_en
  );
endinterface

// File: rtl/vdp_slot_io_bridge.sv
// MSX cartridge-slot I/O front end for the VDP core.
// Synchronises the asynchronous Z80 bus, decodes the four VDP ports at IO_BASE,
// turns each I/O cycle into exactly one request on the core bus, returns read
// data, and drives the slot WAIT, data-direction and INT pins.
module vdp_slot_io_bridge #(
  parameter logic [7:0] IO_BASE = 8'h88
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic                        slot_iorq_n,
  input  logic                        slot_rd_n,
  input  logic                        slot_wr_n,
  input  logic [7:0]                  slot_a,
  input  logic [7:0]                  slot_d_in,
  output logic [7:0]                  slot_d_out,
  output logic                        slot_data_dir,
  output logic                        slot_wait,
  output logic                        slot_intr,
  input  logic                        init_busy,
  input  logic                        vdp_int_n,
  vdp_slot_io_bridge_if.master        bus
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_REQ   = 2'd1;
  localparam logic [1:0] ST_RDATA = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  localparam logic [5:0] PORT_TAG = IO_BASE[7:2];

  // Two-stage synchronisers; control strobes are packed {iorq_n, rd_n, wr_n}
  logic [2:0] ctrl_meta_q, ctrl_q;
  logic [7:0] a_meta_q, a_q;
  logic [7:0] d_meta_q, d_q;

  logic       s_iorq_n, s_rd_n, s_wr_n;
  logic [7:0] s_a, s_d;

  // Request state
  logic [1:0] state_q, state_d;
  logic [1:0] addr_q, addr_d;
  logic       write_q, write_d;
  logic [7:0] wdata_q, wdata_d;

  // Slot-side state
  logic [7:0] dout_q, dout_d;
  logic       dir_q, dir_d;
  logic       wait_q, wait_d;
  logic       intr_q;
  // Set once the current IORQ cycle has been consumed (forwarded or ignored),
  // so a single long access never triggers a second request.
  logic       owned_q, owned_d;

  logic       hit;
  logic       new_hit;
  logic       accept;
  logic       read_pend;

  // Bring the asynchronous Z80 bus into the clk domain
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ctrl_meta_q <= 3'b111;
      ctrl_q      <= 3'b111;
      a_meta_q    <= 8'h00;
      a_q         <= 8'h00;
      d_meta_q    <= 8'h00;
      d_q         <= 8'h00;
    end else begin
      ctrl_meta_q <= {slot_iorq_n, slot_rd_n, slot_wr_n};
      ctrl_q      <= ctrl_meta_q;
      a_meta_q    <= slot_a;
      a_q         <= a_meta_q;
      d_meta_q    <= slot_d_in;
      d_q         <= d_meta_q;
    end
  end

  assign s_iorq_n = ctrl_q[2];
  assign s_rd_n   = ctrl_q[1];
  assign s_wr_n   = ctrl_q[0];
  assign s_a      = a_q;
  assign s_d      = d_q;

  // Port decode; a hit is "new" only if this IORQ cycle has not been consumed yet
  always_comb begin
    hit       = ~s_iorq_n & (~s_wr_n | ~s_rd_n) & (s_a[7:2] == PORT_TAG);
    new_hit   = hit & ~owned_q;
    accept    = (state_q == ST_IDLE) & new_hit & ~init_busy;
    read_pend = ((state_q == ST_REQ) | (state_q == ST_RDATA)) & ~write_q;
  end

  // Request FSM: latch the access, hand it to the core, collect read data,
  // then hold off until the Z80 ends this IORQ cycle (or a new one is already waiting)
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    write_d = write_q;
    wdata_d = wdata_q;
    dout_d  = dout_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          addr_d  = s_a[1:0];
          write_d = ~s_wr_n;
          wdata_d = s_d;
          state_d = ST_REQ;
        end
      end
      ST_REQ: begin
        if (bus.bus_ready) begin
          state_d = write_q ? ST_DONE : ST_RDATA;
        end
      end
      ST_RDATA: begin
        if (bus.bus_rdata_en) begin
          dout_d  = bus.bus_rdata;
          state_d = ST_DONE;
        end
      end
      default: begin
        // owned_q drops when the serviced cycle ends, which also releases a
        // stretched access that arrived while the previous request was pending
        if (s_iorq_n | ~owned_q) begin
          state_d = ST_IDLE;
        end
      end
    endcase
  end

  // Slot-side next state: cycle ownership, data direction and WAIT
  always_comb begin
    // Ownership: cleared between IORQ cycles, taken when IDLE sees a hit
    // (also when init_busy drops it, so that access is never forwarded late)
    owned_d = owned_q;
    if (s_iorq_n) begin
      owned_d = 1'b0;
    end else if ((state_q == ST_IDLE) & new_hit) begin
      owned_d = 1'b1;
    end

    // Drive the slot data bus from an accepted read until /RD or /IORQ rises
    dir_d = dir_q;
    if (s_rd_n | s_iorq_n) begin
      dir_d = 1'b0;
    end else if (accept & s_wr_n) begin
      dir_d = 1'b1;
    end

    // Writes accepted from IDLE are posted; reads and stretched accesses wait
    wait_d = init_busy
           | read_pend
           | (new_hit & (state_q != ST_IDLE))
           | (accept & s_wr_n);
  end

  // State registers for the request FSM and slot-side outputs
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      addr_q  <= 2'd0;
      write_q <= 1'b0;
      wdata_q <= 8'h00;
      dout_q  <= 8'h00;
      dir_q   <= 1'b0;
      wait_q  <= 1'b1;
      owned_q <= 1'b0;
      intr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      write_q <= write_d;
      wdata_q <= wdata_d;
      dout_q  <= dout_d;
      dir_q   <= dir_d;
      wait_q  <= wait_d;
      owned_q <= owned_d;
      intr_q  <= ~vdp_int_n;
    end
  end

  assign bus.bus_valid   = (state_q == ST_REQ);
  assign bus.bus_write   = write_q;
  assign bus.bus_address = addr_q;
  assign bus.bus_wdata   = wdata_q;

  assign slot_d_out    = dout_q;
  assign slot_data_dir = dir_q;
  assign slot_wait     = wait_q;
  assign slot_intr     = intr_q;

endmodule

// File: tb/tb_vdp_slot_io_bridge.sv
// Bench for vdp_slot_io_bridge: drives Z80-style I/O cycles, models a VDP core
// (ready control, delayed read data) and scoreboards every core-bus request.
`timescale 1ns/1ps
module tb_vdp_slot_io_bridge;

  logic       clk = 1'b0;
  always #6 clk = ~clk;

  logic       reset_n;
  logic       iorq_n, rd_n, wr_n;
  logic [7:0] slot_a, slot_d;
  logic [7:0] d_out;
  logic       dir, wt, intr;
  logic       init_busy, vdp_int_n;

  vdp_slot_io_bridge_if bus();

  vdp_slot_io_bridge #(.IO_BASE(8'h88)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .slot_iorq_n  (iorq_n),
    .slot_rd_n    (rd_n),
    .slot_wr_n    (wr_n),
    .slot_a       (slot_a),
    .slot_d_in    (slot_d),
    .slot_d_out   (d_out),
    .slot_data_dir(dir),
    .slot_wait    (wt),
    .slot_intr    (intr),
    .init_busy    (init_busy),
    .vdp_int_n    (vdp_int_n),
    .bus          (bus.master)
  );

  typedef struct {
    logic       wr;
    logic [1:0] addr;
    logic [7:0] data;
  } txn_t;

  txn_t       exp_q[$];
  int         n_checks = 0;
  int         n_pass   = 0;
  int         hs_count = 0;
  int         rd_delay = 0;
  int         ready_hold = 0;
  logic [7:0] rd_value = 8'h00;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  task automatic push_exp(input logic wr, input logic [1:0] addr, input logic [7:0] data);
    txn_t t;
    t.wr = wr; t.addr = addr; t.data = data;
    exp_q.push_back(t);
  endtask

  // One clock: monitor the core bus at negedge, then update the core model after posedge
  task automatic tick();
    txn_t e;
    @(negedge clk);
    if (reset_n && bus.bus_valid && bus.bus_ready) begin
      hs_count++;
      if (exp_q.size() == 0) begin
        check("unexpected_req", 32'(hs_count), 32'd0);
      end else begin
        e = exp_q.pop_front();
        check("req_write", 32'(bus.bus_write), 32'(e.wr));
        check("req_addr", 32'(bus.bus_address), 32'(e.addr));
        if (e.wr) check("req_wdata", 32'(bus.bus_wdata), 32'(e.data));
        $display("txn %0d: %s port %0d data 0x%02h", hs_count,
                 bus.bus_write ? "write" : "read", bus.bus_address, bus.bus_wdata);
      end
      if (!bus.bus_write) rd_delay = 20;
    end
    @(posedge clk);
    #1;
    bus.bus_rdata_en = 1'b0;
    if (rd_delay > 0) begin
      rd_delay--;
      if (rd_delay == 0) begin
        bus.bus_rdata    = rd_value;
        bus.bus_rdata_en = 1'b1;
      end
    end
    if (ready_hold > 0) begin
      ready_hold--;
      if (ready_hold == 0) bus.bus_ready = 1'b1;
    end
  endtask

  // Z80 I/O cycle: strobes low for 'low' clocks, extended while WAIT is high
  task automatic z80_io(input bit is_wr, input logic [7:0] addr, input logic [7:0] data,
                        input int low, input bit honor_wait,
                        output int wait_clks, output logic dir_seen);
    int guard;
    slot_a = addr;
    slot_d = is_wr ? data : 8'h00;
    iorq_n = 1'b0;
    if (is_wr) wr_n = 1'b0;
    else       rd_n = 1'b0;
    wait_clks = 0;
    for (int i = 0; i < low; i++) begin
      tick();
      if (wt) wait_clks++;
    end
    guard = 0;
    while (honor_wait && wt && guard < 1000) begin
      tick();
      wait_clks++;
      guard++;
    end
    if (guard >= 1000) check("wait_bound", 32'(guard), 32'd0);
    tick();
    dir_seen = dir;
    iorq_n = 1'b1;
    rd_n   = 1'b1;
    wr_n   = 1'b1;
    repeat (3) tick();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int   w1, w2, h0, wsum;
    logic ds;

    reset_n = 1'b0; init_busy = 1'b1; vdp_int_n = 1'b1;
    iorq_n = 1'b1; rd_n = 1'b1; wr_n = 1'b1; slot_a = 8'h00; slot_d = 8'h00;
    bus.bus_ready = 1'b1; bus.bus_rdata = 8'h00; bus.bus_rdata_en = 1'b0;

    // Reset values
    @(posedge clk); #1;
    check("rst_wait", 32'(wt), 32'd1);
    check("rst_valid", 32'(bus.bus_valid), 32'd0);
    check("rst_dir", 32'(dir), 32'd0);
    check("rst_dout", 32'(d_out), 32'd0);
    check("rst_intr", 32'(intr), 32'd0);
    reset_n = 1'b1;
    repeat (3) tick();
    check("init_wait", 32'(wt), 32'd1);
    check("init_valid", 32'(bus.bus_valid), 32'd0);

    // Access during init is not forwarded
    h0 = hs_count;
    z80_io(1'b1, 8'h88, 8'h77, 6, 1'b0, w1, ds);
    check("init_ignored", 32'(hs_count - h0), 32'd0);
    init_busy = 1'b0;
    tick(); tick();
    check("init_done_wait", 32'(wt), 32'd0);

    // Interrupt pass-through
    vdp_int_n = 1'b0; tick();
    check("intr_on", 32'(intr), 32'd1);
    vdp_int_n = 1'b1; tick();
    check("intr_off", 32'(intr), 32'd0);

    // Single write at 3.58 MHz timing
    h0 = hs_count;
    push_exp(1'b1, 2'd1, 8'h43);
    z80_io(1'b1, 8'h89, 8'h43, 60, 1'b1, w1, ds);
    check("wr89_one_req", 32'(hs_count - h0), 32'd1);
    check("wr89_no_wait", 32'(w1), 32'd0);

    // Back-to-back writes to port 0x88
    h0 = hs_count; wsum = 0;
    for (int i = 0; i < 1024; i++) begin
      push_exp(1'b1, 2'd0, 8'(i & 255));
      z80_io(1'b1, 8'h88, 8'(i & 255), 5, 1'b1, w1, ds);
      wsum += w1;
    end
    check("bulk_count", 32'(hs_count - h0), 32'd1024);
    check("bulk_no_wait", 32'(wsum), 32'd0);

    // Read port 0x89 with a 20-clock core latency
    rd_value = 8'h9F;
    push_exp(1'b0, 2'd1, 8'h00);
    z80_io(1'b0, 8'h89, 8'h00, 4, 1'b1, w1, ds);
    check("rd_wait_long", 32'(w1 >= 20), 32'd1);
    check("rd_dir_during", 32'(ds), 32'd1);
    check("rd_data", 32'(d_out), 32'h9F);
    check("rd_dir_after", 32'(dir), 32'd0);
    check("rd_wait_after", 32'(wt), 32'd0);

    // Foreign port and top VDP port
    h0 = hs_count;
    z80_io(1'b1, 8'h98, 8'h12, 6, 1'b1, w1, ds);
    check("wr98_no_req", 32'(hs_count - h0), 32'd0);
    check("wr98_no_wait", 32'(w1), 32'd0);
    push_exp(1'b1, 2'd3, 8'hA5);
    z80_io(1'b1, 8'h8B, 8'hA5, 6, 1'b1, w1, ds);
    check("wr8b_one_req", 32'(hs_count - h0), 32'd1);

    // Stalled core: second write is stretched, both are delivered
    h0 = hs_count;
    bus.bus_ready = 1'b0; ready_hold = 200;
    push_exp(1'b1, 2'd2, 8'h11);
    push_exp(1'b1, 2'd2, 8'h22);
    z80_io(1'b1, 8'h8A, 8'h11, 5, 1'b1, w1, ds);
    z80_io(1'b1, 8'h8A, 8'h22, 5, 1'b1, w2, ds);
    check("stall_first_posted", 32'(w1), 32'd0);
    check("stall_second_waits", 32'(w2 > 0), 32'd1);
    check("stall_both_done", 32'(hs_count - h0), 32'd2);

    // Reset in the middle of a pending request
    h0 = hs_count;
    bus.bus_ready = 1'b0;
    slot_a = 8'h88; slot_d = 8'h55; iorq_n = 1'b0; wr_n = 1'b0;
    for (int i = 0; i < 20 && !bus.bus_valid; i++) tick();
    check("mid_req_valid", 32'(bus.bus_valid), 32'd1);
    reset_n = 1'b0;
    tick();
    check("mid_rst_valid", 32'(bus.bus_valid), 32'd0);
    check("mid_rst_wait", 32'(wt), 32'd1);
    iorq_n = 1'b1; wr_n = 1'b1;
    repeat (3) tick();
    reset_n = 1'b1; bus.bus_ready = 1'b1;
    repeat (4) tick();
    check("mid_rst_dropped", 32'(hs_count - h0), 32'd0);
    check("mid_rst_wait_clear", 32'(wt), 32'd0);

    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
